// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder on the load/store path of the single-cycle core.
// Holds a word-organised storage array. Stores write byte lanes. Loads have
// a registered read, and the selected lane is then sign- or zero-extended.
//
// Load timeline:
//   edge N   : the request is sampled, the array word is read into rd_word_q,
//              and lane, size, extension mode and the pending flag are captured.
//   edge N+1 : the extended data, rd_valid and acc_err are registered.
//
// Optional feature (compile-time macro DMEM_MISALIGN_CHECK_EN):
//   When defined, half accesses with addr[0]=1 and word accesses with
//   addr[1:0]!=0 are misaligned. A misaligned store is dropped. A misaligned
//   load returns 0 with rd_valid. Both raise acc_err.
//   When undefined, the ignored low address bits are dropped silently.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   addr          byte address: word index = addr[ADDR_W-1:2], lane = addr[1:0]
//   rd_en/wr_en   load/store request, sampled on the rising edge
//   size          00 byte, 01 half, 10 word, 11 word
//   load_unsigned 1 = zero-extend, 0 = sign-extend
//   dmem_wr_data  right-justified store data
//   dmem_rd_data  extended load data; holds its value between loads
//   rd_valid      one-cycle pulse that marks valid load data
//   acc_err       one-cycle pulse for a rd/wr conflict or a misaligned access
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 8192,
    parameter int ADDR_W      = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [1:0]        size,
    input  logic              load_unsigned,
    input  logic [31:0]       dmem_wr_data,
    output logic [31:0]       dmem_rd_data,
    output logic              rd_valid,
    output logic              acc_err
);

    localparam int IDX_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    // State captured for a load between the array read and the output stage.
    typedef struct packed {
        logic [1:0] lane;     // normalised lane of the access
        size_e      size;
        logic       uns;      // zero-extend
        logic       zero;     // misaligned load: force the data to 0
        logic       pending;  // a load was accepted on the last edge
        logic       err;      // conflict or misalignment on the last edge
    } cap_t;

    logic [IDX_W-1:0] word_idx;
    size_e            req_size;
    logic             misaligned;
    logic [1:0]       lane;
    logic             rd_fire;
    logic             wr_fire;
    logic [3:0]       wr_be;
    logic [31:0]      wr_word;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [31:0]      rd_word_q;

    cap_t             cap_d, cap_q;
    logic [31:0]      dmem_rd_data_d, dmem_rd_data_q;
    logic             rd_valid_d, rd_valid_q;
    logic             acc_err_d, acc_err_q;
    logic [31:0]      ext_data;

    assign word_idx = addr[ADDR_W-1:2];
    assign req_size = size_e'(size);

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misaligned = ((req_size == SZ_HALF) && addr[0]) ||
                        (size[1] && (addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // A simultaneous read and write keeps the write and drops the read.
    assign rd_fire = rd_en && !wr_en;
    assign wr_fire = wr_en && !misaligned;

    // Normalise the lane so that the bits a size ignores never select data.
    // Replicate the store data across the lanes so that each enabled lane
    // can take its byte from its own position.
    // NOTE: every always_comb output is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        lane    = addr[1:0];
        wr_be   = 4'b1111;
        wr_word = dmem_wr_data;
        unique case (req_size)
            SZ_BYTE: begin
                wr_be   = 4'b0001 << addr[1:0];
                wr_word = {4{dmem_wr_data[7:0]}};
            end
            SZ_HALF: begin
                lane    = {addr[1], 1'b0};
                wr_be   = addr[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{dmem_wr_data[15:0]}};
            end
            SZ_WORD, SZ_RSVD: begin
                lane    = 2'b00;
            end
        endcase
    end

    // NOTE: the array and its read register have no reset, so they can map
    // onto RAM. Gating the write with rst_n stops any store from committing
    // while reset is held. The contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (wr_fire) begin
                for (int i = 0; i < 4; i++) begin
                    if (wr_be[i]) begin
                        mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
                    end
                end
            end
            if (rd_fire) begin
                rd_word_q <= mem[word_idx];
            end
        end
    end

    // Capture stage. The load fields only update on an accepted load.
    always_comb begin
        cap_d         = cap_q;
        cap_d.pending = rd_fire;
        cap_d.err     = (rd_en && wr_en) || ((rd_en || wr_en) && misaligned);
        if (rd_fire) begin
            cap_d.lane = lane;
            cap_d.size = req_size;
            cap_d.uns  = load_unsigned;
            cap_d.zero = misaligned;
        end
    end

    // Extract and extend the loaded lane.
    always_comb begin
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v   = rd_word_q[8*cap_q.lane +: 8];
        half_v   = rd_word_q[16*cap_q.lane[1] +: 16];
        ext_data = rd_word_q;
        unique case (cap_q.size)
            SZ_BYTE: ext_data = {{24{byte_v[7]  && !cap_q.uns}}, byte_v};
            SZ_HALF: ext_data = {{16{half_v[15] && !cap_q.uns}}, half_v};
            SZ_WORD, SZ_RSVD: ext_data = rd_word_q;
        endcase
    end

    // Output stage. The data register only updates when a load completes.
    always_comb begin
        rd_valid_d     = cap_q.pending;
        acc_err_d      = cap_q.err;
        dmem_rd_data_d = dmem_rd_data_q;
        if (cap_q.pending) begin
            dmem_rd_data_d = cap_q.zero ? 32'h0 : ext_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q          <= '0;
            dmem_rd_data_q <= 32'h0;
            rd_valid_q     <= 1'b0;
            acc_err_q      <= 1'b0;
        end else begin
            cap_q          <= cap_d;
            dmem_rd_data_q <= dmem_rd_data_d;
            rd_valid_q     <= rd_valid_d;
            acc_err_q      <= acc_err_d;
        end
    end

    assign dmem_rd_data = dmem_rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign acc_err      = acc_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Drives directed and randomized load/store traffic into dmem_responder.
// A byte-lane memory model computes the expected output for every request:
// rd_valid, acc_err and the extended data. A compare process checks the DUT
// on every falling edge. Literal checks pin the model's predictions for the
// hand-computed cases.
// Build with DMEM_MISALIGN_CHECK_EN defined to exercise the alignment check.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int ADDR_W = 15;
`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit CHECK_ALIGN = 1'b1;
`else
    localparam bit CHECK_ALIGN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic              rd_en = 1'b0;
    logic              wr_en = 1'b0;
    logic [1:0]        size = 2'b10;
    logic              load_unsigned = 1'b0;
    logic [31:0]       dmem_wr_data = '0;
    logic [31:0]       dmem_rd_data;
    logic              rd_valid;
    logic              acc_err;

    dmem_responder #(.DEPTH_WORDS(8192), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .addr         (addr),
        .rd_en        (rd_en),
        .wr_en        (wr_en),
        .size         (size),
        .load_unsigned(load_unsigned),
        .dmem_wr_data (dmem_wr_data),
        .dmem_rd_data (dmem_rd_data),
        .rd_valid     (rd_valid),
        .acc_err      (acc_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          valid;
        bit          err;
        logic [31:0] data;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          chk_en = 1'b0;
    logic [31:0] last_data = '0;
    logic [31:0] pred;
    exp_t        q[$];
    logic [31:0] model_mem [int];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] sz,
                                             input bit uns, input logic [ADDR_W-1:0] a);
        logic [31:0] v;
        case (sz)
            2'b00: begin
                v = (w >> (8 * a[1:0])) & 32'hFF;
                if (!uns && v[7]) v = v | 32'hFFFFFF00;
            end
            2'b01: begin
                v = (w >> (16 * a[1])) & 32'hFFFF;
                if (!uns && v[15]) v = v | 32'hFFFF0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] store_val(input logic [31:0] old, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [ADDR_W-1:0] a);
        logic [31:0] m;
        int          sh;
        case (sz)
            2'b00:   begin sh = 8 * a[1:0]; m = 32'hFF << sh;   end
            2'b01:   begin sh = 16 * a[1];  m = 32'hFFFF << sh; end
            default: begin sh = 0;          m = 32'hFFFFFFFF;   end
        endcase
        return (old & ~m) | ((d << sh) & m);
    endfunction

    // One request per cycle: drive the inputs, predict the response, update the model.
    task automatic req(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [ADDR_W-1:0] a, input logic [31:0] wd);
        exp_t        e;
        bit          mis;
        int          idx;
        logic [31:0] old;
        rd_en = rd; wr_en = wr; size = sz; load_unsigned = uns; addr = a; dmem_wr_data = wd;
        mis = CHECK_ALIGN && (rd || wr) && ((sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00));
        idx = int'(a[ADDR_W-1:2]);
        old = model_mem.exists(idx) ? model_mem[idx] : 32'hxxxxxxxx;
        e.due   = cyc + 2;
        e.valid = rd && !wr;
        e.err   = (rd && wr) || mis;
        e.data  = (e.valid && !mis) ? load_val(old, sz, uns, a) : 32'h0;
        pred    = e.data;
        if (e.valid || e.err) q.push_back(e);
        if (wr && !mis) model_mem[idx] = store_val(old, wd, sz, a);
        @(negedge clk); #1;
    endtask

    task automatic idle();
        rd_en = 1'b0; wr_en = 1'b0;
        @(negedge clk); #1;
    endtask

    // The compare process expects idle outputs whenever no response is due.
    initial begin : compare
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (q.size() > 0 && q[0].due == cyc) begin
                    e = q.pop_front();
                end else begin
                    e.due = cyc; e.valid = 1'b0; e.err = 1'b0; e.data = last_data;
                end
                check("rd_valid", 32'(rd_valid), 32'(e.valid));
                check("acc_err", 32'(acc_err), 32'(e.err));
                if (e.valid) last_data = e.data;
                check("rd_data", dmem_rd_data, last_data);
            end
        end
    end

    initial begin : stim
        // Reset for 3 cycles, then check that all outputs are zero.
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        check("rst_rd_data", dmem_rd_data, 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_acc_err", 32'(acc_err), 32'h0);
        last_data = 32'h0;
        chk_en = 1'b1;

        // SW then LW on the next cycle; the data arrives one cycle after the load.
        req(0, 1, 2'b10, 0, 15'h0010, 32'hDEADBEEF);
        req(1, 0, 2'b10, 0, 15'h0010, 32'h0);
        check("pred_lw10", pred, 32'hDEADBEEF);
        check("lw_lat_early", 32'(rd_valid), 32'h0);
        idle();
        check("lw_lat_valid", 32'(rd_valid), 32'h1);
        check("lw_lat_data", dmem_rd_data, 32'hDEADBEEF);

        // Byte lanes and extension.
        req(0, 1, 2'b10, 0, 15'h0020, 32'h0);
        req(0, 1, 2'b00, 0, 15'h0022, 32'h80);
        req(1, 0, 2'b00, 0, 15'h0022, 32'h0); check("pred_lb22", pred, 32'hFFFFFF80);
        req(1, 0, 2'b00, 1, 15'h0022, 32'h0); check("pred_lbu22", pred, 32'h00000080);
        req(1, 0, 2'b10, 0, 15'h0020, 32'h0); check("pred_lw20", pred, 32'h00800000);

        // Half lanes.
        req(0, 1, 2'b01, 0, 15'h0032, 32'h8001);
        req(0, 1, 2'b01, 0, 15'h0030, 32'h1234);
        req(1, 0, 2'b10, 0, 15'h0030, 32'h0); check("pred_lw30", pred, 32'h80011234);
        req(1, 0, 2'b01, 0, 15'h0032, 32'h0); check("pred_lh32", pred, 32'hFFFF8001);
        req(1, 0, 2'b01, 1, 15'h0032, 32'h0); check("pred_lhu32", pred, 32'h00008001);

        // Back-to-back loads.
        req(1, 0, 2'b10, 0, 15'h0010, 32'h0); check("pred_b2b0", pred, 32'hDEADBEEF);
        req(1, 0, 2'b10, 0, 15'h0020, 32'h0); check("pred_b2b1", pred, 32'h00800000);
        req(1, 0, 2'b10, 0, 15'h0030, 32'h0); check("pred_b2b2", pred, 32'h80011234);
        req(1, 0, 2'b10, 0, 15'h0010, 32'h0); check("pred_b2b3", pred, 32'hDEADBEEF);
        idle();
        idle();

        // A read/write conflict keeps the write and drops the read.
        req(1, 1, 2'b10, 0, 15'h0040, 32'h5A5A5A5A);
        idle();
        check("conflict_err", 32'(acc_err), 32'h1);
        check("conflict_no_valid", 32'(rd_valid), 32'h0);
        req(1, 0, 2'b10, 0, 15'h0040, 32'h0); check("pred_lw40", pred, 32'h5A5A5A5A);
        idle();
        idle();

        // Reset after a load is sampled cancels its rd_valid.
        rd_en = 1'b1; wr_en = 1'b0; size = 2'b10; addr = 15'h0010;
        @(posedge clk); #1;
        rst_n = 1'b0; rd_en = 1'b0;
        chk_en = 1'b0;
        q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_valid", 32'(rd_valid), 32'h0);
            check("rst_mid_data", dmem_rd_data, 32'h0);
        end
        #1 rst_n = 1'b1;
        last_data = 32'h0;
        chk_en = 1'b1;
        req(1, 0, 2'b10, 0, 15'h0040, 32'h0);
        idle();
        check("retained_lw40", dmem_rd_data, 32'h5A5A5A5A);

`ifdef DMEM_MISALIGN_CHECK_EN
        req(1, 0, 2'b10, 0, 15'h0011, 32'h0); check("pred_mis_lw", pred, 32'h0);
        idle();
        check("mis_lw_valid", 32'(rd_valid), 32'h1);
        check("mis_lw_err", 32'(acc_err), 32'h1);
        check("mis_lw_data", dmem_rd_data, 32'h0);
        req(0, 1, 2'b01, 0, 15'h0013, 32'hFFFF);
        req(1, 0, 2'b10, 0, 15'h0010, 32'h0); check("pred_mis_sh", pred, 32'hDEADBEEF);
`else
        req(1, 0, 2'b10, 0, 15'h0011, 32'h0); check("pred_unal_lw", pred, 32'hDEADBEEF);
        idle();
        check("unal_lw_err", 32'(acc_err), 32'h0);
        check("unal_lw_data", dmem_rd_data, 32'hDEADBEEF);
`endif

        // Randomized traffic over a pre-initialised 16-word region.
        for (int i = 0; i < 16; i++) begin
            req(0, 1, 2'b10, 0, 15'(32'h100 + 4 * i), $urandom);
        end
        for (int i = 0; i < 600; i++) begin
            int          op;
            logic [1:0]  sz;
            logic [ADDR_W-1:0] a;
            op = $urandom_range(0, 9);
            sz = 2'($urandom_range(0, 3));
            a  = 15'(32'h100 + $urandom_range(0, 63));
            if (op <= 3)      req(1, 0, sz, 1'($urandom), a, 32'h0);
            else if (op <= 6) req(0, 1, sz, 1'($urandom), a, $urandom);
            else if (op == 7) req(1, 1, sz, 1'($urandom), a, $urandom);
            else              idle();
        end

        repeat (3) idle();
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
